fetch_unit: RTL and testbench

//   Instruction-fetch stage of the RV32I core; sits directly upstream of the main decoder.

---
 rtl/fetch_unit.sv | 132 +++++++++++++
 tb/tb_fetch_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction-fetch stage. Holds the PC, issues one
// request per instruction to a variable-latency imem and holds the word.
// Ports:
//   clk, reset          core clock, synchronous active-high reset
//   imem_req/imem_addr  one-cycle fetch request and word address (= PC)
//   imem_rvalid/rdata   response, sampled only while waiting
//   advance             held instruction executed; commit next PC
//   PCSrc/PCTarget      next-PC select and target from datapath
//   instr_valid/Instr   held instruction and its valid flag
//   op                  Instr[6:0] to the main decoder
//   PC/PCPlus4          held instruction address and PC + 4
//   fault               sticky misaligned-fetch fault
//   retire_count        accepted advances, wraps at 2^32
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        advance,
  input  logic [1:0]  PCSrc,
  input  logic [31:0] PCTarget,
  output logic        instr_valid,
  output logic [31:0] Instr,
  output logic [6:0]  op,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        fault,
  output logic [31:0] retire_count
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  state_t      state_q;
  logic        req_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        valid_q;
  logic        fault_q;
  logic [31:0] retire_q;

  logic [31:0] pc_plus4;
  logic [31:0] next_pc_d;
  logic [31:0] retire_d;
  logic        next_ok;

  assign pc_plus4 = pc_q + 32'd4;
  assign retire_d = retire_q + 32'd1;

  always_comb begin
    next_pc_d = pc_plus4;
    unique case (PCSrc)
      2'b01:   next_pc_d = PCTarget;
      2'b10:   next_pc_d = {PCTarget[31:1], 1'b0};
      default: next_pc_d = pc_plus4;
    endcase
  end

  assign next_ok = (next_pc_d[1:0] == 2'b00);

  // REQ with req_q low is the post-reset slot: it raises the request
  // one cycle after reset drops, so imem_req stays low during reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_REQ;
      req_q    <= 1'b0;
      pc_q     <= RESET_PC;
      instr_q  <= NOP;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
      retire_q <= 32'd0;
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (req_q) begin
            req_q   <= 1'b0;
            state_q <= S_WAIT;
          end else begin
            req_q   <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            instr_q <= imem_rdata;
            valid_q <= 1'b1;
            state_q <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (advance) begin
            retire_q <= retire_d;
            valid_q  <= 1'b0;
            if (next_ok) begin
              pc_q    <= next_pc_d;
              req_q   <= 1'b1;
              state_q <= S_REQ;
            end else begin
              fault_q <= 1'b1;
              state_q <= S_FAULT;
            end
          end
        end
        S_FAULT: begin
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
        default: state_q <= S_FAULT;
      endcase
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = pc_q;
  assign instr_valid  = valid_q;
  assign Instr        = instr_q;
  assign op           = instr_q[6:0];
  assign PC           = pc_q;
  assign PCPlus4      = pc_plus4;
  assign fault        = fault_q;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit.
// Drives imem responses by hand and checks fetch/advance/fault/wrap.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        advance;
  logic [1:0]  PCSrc;
  logic [31:0] PCTarget;
  logic        instr_valid;
  logic [31:0] Instr;
  logic [6:0]  op;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        fault;
  logic [31:0] retire_count;

  int n_assert;
  int n_fail;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .advance      (advance),
    .PCSrc        (PCSrc),
    .PCTarget     (PCTarget),
    .instr_valid  (instr_valid),
    .Instr        (Instr),
    .op           (op),
    .PC           (PC),
    .PCPlus4      (PCPlus4),
    .fault        (fault),
    .retire_count (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expects the request to be visible now; answers after lat cycles.
  task automatic fetch(input int lat,
                       input logic [31:0] data,
                       input logic [31:0] addr,
                       input logic noise);
    chk("req_hi", {31'd0, imem_req}, 32'd1);
    chk("req_addr", imem_addr, addr);
    for (int i = 1; i < lat; i++) begin
      advance = noise;
      PCSrc = 2'b01;
      PCTarget = 32'h0000_0400;
      tick();
      chk("wait_req_lo", {31'd0, imem_req}, 32'd0);
      chk("wait_vld_lo", {31'd0, instr_valid}, 32'd0);
    end
    tick();
    chk("wait_req_lo2", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata = data;
    tick();
    imem_rvalid = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    advance = 1'b0;
    chk("hold_vld", {31'd0, instr_valid}, 32'd1);
    chk("hold_instr", Instr, data);
    chk("hold_pc", PC, addr);
    chk("hold_req_lo", {31'd0, imem_req}, 32'd0);
  endtask

  task automatic adv(input logic [1:0] src,
                     input logic [31:0] tgt);
    advance = 1'b1;
    PCSrc = src;
    PCTarget = tgt;
    tick();
    advance = 1'b0;
    PCSrc = 2'b00;
  endtask

  initial begin
    n_assert = 0;
    n_fail = 0;
    reset = 1'b1;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    advance = 1'b0;
    PCSrc = 2'b00;
    PCTarget = 32'h0;
    tick();
    tick();
    chk("rst_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc", PC, 32'h0000_0100);
    chk("rst_instr", Instr, 32'h0000_0013);
    chk("rst_vld", {31'd0, instr_valid}, 32'd0);
    chk("rst_fault", {31'd0, fault}, 32'd0);
    chk("rst_ret", retire_count, 32'd0);
    reset = 1'b0;
    tick();

    // 1: first fetch, 1-cycle memory
    fetch(1, 32'h0050_0093, 32'h0000_0100, 1'b0);
    chk("t1_op", {25'd0, op}, 32'h0000_0013);
    chk("t1_pc4", PCPlus4, 32'h0000_0104);
    tick();
    chk("t1_stay", {31'd0, instr_valid}, 32'd1);
    chk("t1_noreq", {31'd0, imem_req}, 32'd0);

    // 2: sequential advance
    adv(2'b00, 32'h0000_0AA0);
    chk("t2_req", {31'd0, imem_req}, 32'd1);
    chk("t2_addr", imem_addr, 32'h0000_0104);
    chk("t2_ret", retire_count, 32'd1);
    chk("t2_vld", {31'd0, instr_valid}, 32'd0);
    fetch(1, 32'h0000_0463, 32'h0000_0104, 1'b0);
    chk("t2_op", {25'd0, op}, 32'h0000_0063);

    // 3: branch to 0x200, 4-cycle memory, advance ignored in WAIT
    adv(2'b01, 32'h0000_0200);
    chk("t3_addr", imem_addr, 32'h0000_0200);
    chk("t3_ret", retire_count, 32'd2);
    fetch(4, 32'h0040_006F, 32'h0000_0200, 1'b1);
    chk("t3_ret_keep", retire_count, 32'd2);
    chk("t3_pc4", PCPlus4, 32'h0000_0204);

    // PCSrc=11 behaves as PC+4
    adv(2'b11, 32'h0000_0800);
    chk("t2b_req", {31'd0, imem_req}, 32'd1);
    chk("t2b_addr", imem_addr, 32'h0000_0204);
    chk("t2b_ret", retire_count, 32'd3);
    fetch(2, 32'h0000_8067, 32'h0000_0204, 1'b0);

    // 4: jalr clears bit 0
    adv(2'b10, 32'h0000_0305);
    chk("t4_addr", imem_addr, 32'h0000_0304);
    chk("t4_ret", retire_count, 32'd4);
    fetch(1, 32'h0000_0013, 32'h0000_0304, 1'b0);

    // misaligned target -> sticky fault
    adv(2'b01, 32'h0000_0102);
    chk("t4_fault", {31'd0, fault}, 32'd1);
    chk("t4_vld", {31'd0, instr_valid}, 32'd0);
    chk("t4_ret_f", retire_count, 32'd5);
    chk("t4_pc", PC, 32'h0000_0304);
    chk("t4_noreq", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1;
    imem_rdata = 32'h1234_5678;
    advance = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_f_req", {31'd0, imem_req}, 32'd0);
      chk("t4_f_flt", {31'd0, fault}, 32'd1);
      chk("t4_f_vld", {31'd0, instr_valid}, 32'd0);
    end
    imem_rvalid = 1'b0;
    advance = 1'b0;
    chk("t4_f_ret", retire_count, 32'd5);
    chk("t4_f_ins", Instr, 32'h0000_0013);

    // 5: reset clears fault, then reset in WAIT of a 3-cycle fetch
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_flt_clr", {31'd0, fault}, 32'd0);
    chk("t5_rq_lo", {31'd0, imem_req}, 32'd0);
    tick();
    chk("t5_req", {31'd0, imem_req}, 32'd1);
    chk("t5_addr", imem_addr, 32'h0000_0100);
    tick();
    chk("t5_w_req", {31'd0, imem_req}, 32'd0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t5_pc", PC, 32'h0000_0100);
    chk("t5_ret", retire_count, 32'd0);
    chk("t5_flt", {31'd0, fault}, 32'd0);
    chk("t5_vld", {31'd0, instr_valid}, 32'd0);
    chk("t5_rq0", {31'd0, imem_req}, 32'd0);
    tick();
    fetch(3, 32'h0010_0113, 32'h0000_0100, 1'b0);

    // 6: PC wrap and retire_count wrap
    adv(2'b01, 32'hFFFF_FFFC);
    chk("t6_addr", imem_addr, 32'hFFFF_FFFC);
    fetch(1, 32'h0000_0013, 32'hFFFF_FFFC, 1'b0);
    chk("t6_pc4", PCPlus4, 32'h0000_0000);
    force dut.retire_q = 32'hFFFF_FFFE;
    #1;
    release dut.retire_q;
    #1;
    adv(2'b00, 32'h0);
    chk("t6_wrap", imem_addr, 32'h0000_0000);
    chk("t6_req", {31'd0, imem_req}, 32'd1);
    chk("t6_ret_max", retire_count, 32'hFFFF_FFFF);
    fetch(1, 32'h0000_0013, 32'h0000_0000, 1'b0);
    adv(2'b00, 32'h0);
    chk("t6_ret_wrap", retire_count, 32'd0);
    chk("t6_addr4", imem_addr, 32'h0000_0004);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
